guitar_strum_sequencer: RTL and testbench
=========================================

Name: guitar_strum_sequencer

Overview:
- Consumes the 7-bit per-string pluck pattern produced by the keyboard note mux.
- Converts each new pattern into per-string one-cycle trigger pulses for the string synthesis voices.
- Single notes fire immediately. Chords are strummed, one string at a time, with a programmable gap between pulses.
- Sits between the keyboard note mux and the per-string guitar voice generators.

Parameters:
- STRUM_GAP, 4: clock cycles between successive string pulses of one strum. Legal range 1..65535.
- NUM_STRINGS, 7: number of string bits. Fixed at 7 for this design.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous active-low reset.
- pluck  input  7  level pattern from the note mux, held while the key is held. 0 means no key.
- string_trig  output  7  one-cycle pulse per string to be plucked. At most one bit set per cycle.
- busy  output  1  high while a strum is in progress.
- strum_done  output  1  one-cycle pulse coincident with the final string_trig pulse of a strum.
- active_mask  output  7  pattern of the strum currently playing or last played.
- pending_valid  output  1  a queued pattern is waiting to start.

Behaviour:
- Reset (async, Reset_n=0):
  - string_trig=0, busy=0, strum_done=0, active_mask=0, pending_valid=0.
  - pluck_prev=0, state=IDLE.
  - Reset may assert at any time, including mid-strum. No further pulses are issued until it deasserts.
- Event detection:
  - pluck is registered into pluck_prev every cycle.
  - An event occurs on a clock edge where pluck != pluck_prev and pluck != 0.
  - Release (pluck goes to 0) is never an event and does not abort a strum.
  - A steady held pattern never retriggers.
  - Re-pressing the same pattern after a release is an event.
  - Because pluck_prev resets to 0, a pattern held through reset deassertion is an event on the first edge after deassertion.
- State machine (states IDLE, FIRE, WAIT):
  - IDLE: on an event, latch pluck into active_mask and a working mask, then go to FIRE.
  - FIRE: assert string_trig for the lowest set bit of the working mask, clear that bit, load the gap counter with STRUM_GAP-1.
    - If the working mask is now empty: assert strum_done this cycle. Go to IDLE, or start the pending pattern if one is queued.
    - Otherwise go to WAIT.
  - WAIT: decrement the gap counter. At 0, go to FIRE.
- Timing:
  - The first pulse appears in the cycle after the event edge (1-cycle latency).
  - Pulse-to-pulse spacing is exactly STRUM_GAP cycles.
  - A pattern with k set bits completes in 1+(k-1)*STRUM_GAP cycles from the first pulse.
- busy: high from the first pulse cycle through the final pulse cycle inclusive. Low in IDLE.
- Events while busy:
  - The pattern is stored in a one-deep pending register and pending_valid is set.
  - A later event overwrites the pending pattern; the last one wins.
  - On strum_done with pending valid:
    - the pending pattern loads into active_mask and the working mask, and pending_valid clears;
    - the first pending pulse occurs STRUM_GAP cycles after the final pulse, via WAIT.
    - busy stays high across the transition.
- Simultaneous event and strum_done in the same cycle: the event is treated as pending and starts per the rule above.
- Gap counter width: clog2(STRUM_GAP+1) bits. No wrap; it saturates at 0.

Optional Feature:
- Macro: STRUM_ALTERNATE_EN.
- Defined:
  - A direction flag toggles after each strum containing 2 or more strings.
  - Even-numbered chords (first after reset = 0) strum lowest bit first; odd-numbered chords strum highest bit first.
  - Single-string patterns ignore the flag and do not toggle it.
  - The flag resets to 0.
- Undefined: always lowest set bit first. No flag register exists.

Test Plan:
- Single note (STRUM_GAP=4): pluck=0000010 at edge T -> string_trig=0000010 at T+1 only; strum_done at T+1; busy low at T+2; active_mask=0000010.
- Chord: pluck=1111100 at T -> pulses on bits 2,3,4,5,6 at T+1,T+5,T+9,T+13,T+17; strum_done at T+17; busy high T+1..T+17.
- Hold and re-press: hold pluck=0001000 for 100 cycles -> exactly 1 pulse. Then set pluck=0 for 3 cycles, then 0001000 again -> a second pulse 1 cycle after the re-press.
- Queue and overwrite: pluck=1111111 at T, then 0000100 at T+3, then 0100000 at T+6:
  - pending_valid high from T+4;
  - 7 pulses end at T+25 with strum_done;
  - string_trig=0100000 at T+29; 0000100 is never fired.
- Reset mid-strum: start 1111000, assert Reset_n=0 after the second pulse -> all outputs 0 immediately. Deassert with pluck still 1111000 -> a fresh strum starts with bit 3 one cycle after the first edge.
- STRUM_ALTERNATE_EN defined: chord 1111100 then (after release) 1111100 again -> first strum order bits 2..6, second order bits 6..2. An interleaved 0000010 does not change the alternation.

Source files
------------

// File: rtl/guitar_strum_sequencer.sv
// guitar_strum_sequencer
// Turns each new pluck pattern from the keyboard note mux into one-cycle
// per-string trigger pulses for the string voices. A single note fires
// straight away. A chord is strummed one string at a time, STRUM_GAP cycles
// apart. One further pattern can be queued while a strum is playing; the
// newest queued pattern wins.
//
// Optional feature, macro STRUM_ALTERNATE_EN:
//   defined   - the strum direction alternates after every chord of two or
//               more strings (even chords low->high, odd chords high->low).
//   undefined - every strum runs lowest set bit first; no direction flag.
module guitar_strum_sequencer #(
    parameter int STRUM_GAP   = 4,
    parameter int NUM_STRINGS = 7
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [NUM_STRINGS-1:0] pluck,
    output logic [NUM_STRINGS-1:0] string_trig,
    output logic                   busy,
    output logic                   strum_done,
    output logic [NUM_STRINGS-1:0] active_mask,
    output logic                   pending_valid
);

    localparam int               CNT_W    = $clog2(STRUM_GAP + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(STRUM_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_STRINGS-1:0] pluck_prev_q, pluck_prev_d;
    logic [NUM_STRINGS-1:0] work_q, work_d;
    logic [NUM_STRINGS-1:0] active_q, active_d;
    logic [NUM_STRINGS-1:0] pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   event_w;
    logic                   hi_first;
    logic [NUM_STRINGS-1:0] pick;
    logic [NUM_STRINGS-1:0] work_left;
    logic [NUM_STRINGS-1:0] next_pat;

    // One-hot of the lowest set bit (zero when the mask is empty).
    function automatic logic [NUM_STRINGS-1:0] lowest_bit(input logic [NUM_STRINGS-1:0] m);
        logic [NUM_STRINGS-1:0] r;
        r = '0;
        for (int i = NUM_STRINGS - 1; i >= 0; i--) begin
            if (m[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // One-hot of the highest set bit (zero when the mask is empty).
    function automatic logic [NUM_STRINGS-1:0] highest_bit(input logic [NUM_STRINGS-1:0] m);
        logic [NUM_STRINGS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_STRINGS; i++) begin
            if (m[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

`ifdef STRUM_ALTERNATE_EN
    logic dir_q, dir_d;
    logic multi;

    // The flag only moves on chords; single notes leave the alternation alone.
    assign multi    = (active_q & ~lowest_bit(active_q)) != '0;
    assign hi_first = dir_q;
`else
    assign hi_first = 1'b0;
`endif

    // A new non-zero pattern is an event; releases and steady holds are not.
    assign event_w   = (pluck != pluck_prev_q) && (pluck != '0);
    assign pick      = hi_first ? highest_bit(work_q) : lowest_bit(work_q);
    assign work_left = work_q & ~pick;
    // An event in the final pulse cycle outranks an older queued pattern.
    assign next_pat  = event_w ? pluck : pend_q;

    // Next-state and pulse decode for the strum sequencer.
    always_comb begin
        state_d      = state_q;
        pluck_prev_d = pluck;
        work_d       = work_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        cnt_d        = cnt_q;
        string_trig  = '0;
        strum_done   = 1'b0;
`ifdef STRUM_ALTERNATE_EN
        dir_d        = dir_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (event_w) begin
                    active_d = pluck;
                    work_d   = pluck;
                    state_d  = S_FIRE;
                end
            end

            S_FIRE: begin
                string_trig = pick;
                work_d      = work_left;
                cnt_d       = GAP_LOAD;
                if (work_left == '0) begin
                    strum_done = 1'b1;
`ifdef STRUM_ALTERNATE_EN
                    if (multi) begin
                        dir_d = ~dir_q;
                    end
`endif
                    if (event_w || pend_vld_q) begin
                        // Chain straight into the queued strum; the usual gap
                        // still separates its first pulse from our last one.
                        active_d   = next_pat;
                        work_d     = next_pat;
                        pend_vld_d = 1'b0;
                        state_d    = (GAP_LOAD == '0) ? S_FIRE : S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (event_w) begin
                        pend_d     = pluck;
                        pend_vld_d = 1'b1;
                    end
                    state_d = (GAP_LOAD == '0) ? S_FIRE : S_WAIT;
                end
            end

            S_WAIT: begin
                if (event_w) begin
                    pend_d     = pluck;
                    pend_vld_d = 1'b1;
                end
                // Counter was loaded with GAP-1 in FIRE, so leaving when it
                // would reach zero gives exactly GAP cycles pulse-to-pulse.
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = S_FIRE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            pluck_prev_q <= '0;
            work_q       <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pluck_prev_q <= pluck_prev_d;
            work_q       <= work_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef STRUM_ALTERNATE_EN
    // Strum direction flag; chord 0 after reset runs low to high.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign busy          = (state_q != S_IDLE);
    assign active_mask   = active_q;
    assign pending_valid = pend_vld_q;

endmodule

// File: tb/tb_guitar_strum_sequencer.sv
// Bench for guitar_strum_sequencer. A schedule-based model (pulse times from
// start time + index*GAP, pattern queue of depth one) is compared against the
// DUT on every negedge; directed sequences pin the model with literal values,
// then randomized patterns, holds and resets run against the model.
module tb_guitar_strum_sequencer;

    localparam int G = 4;

    logic       Clk;
    logic       Reset_n;
    logic [6:0] pluck;
    logic [6:0] string_trig;
    logic       busy;
    logic       strum_done;
    logic [6:0] active_mask;
    logic       pending_valid;

    int checks = 0;
    int errors = 0;

    guitar_strum_sequencer #(.STRUM_GAP(G), .NUM_STRINGS(7)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .pluck        (pluck),
        .string_trig  (string_trig),
        .busy         (busy),
        .strum_done   (strum_done),
        .active_mask  (active_mask),
        .pending_valid(pending_valid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A strum is a start cycle, an ordered list of strings and a final cycle;
    // cycle n carries a pulse when (n - start) is a multiple of G.
    int         cyc     = 0;
    int         m_s     = -1000;
    int         m_f     = -1000;
    int         m_chain = -1000;
    logic [6:0] m_order [0:6];
    logic [6:0] m_prev   = '0;
    logic [6:0] m_active = '0;
    logic [6:0] m_pend   = '0;
    logic       m_pv     = 1'b0;
    logic       m_flag   = 1'b0;

    function automatic void m_reset();
        m_s = -1000; m_f = -1000; m_chain = -1000;
        m_prev = '0; m_active = '0; m_pend = '0; m_pv = 1'b0; m_flag = 1'b0;
        for (int j = 0; j < 7; j++) m_order[j] = '0;
    endfunction

    function automatic void m_start(input logic [6:0] m, input int s);
        int   k;
        logic hi;
        k  = 0;
        hi = 1'b0;
`ifdef STRUM_ALTERNATE_EN
        hi = m_flag;
`endif
        for (int j = 0; j < 7; j++) m_order[j] = '0;
        for (int j = 0; j < 7; j++) begin
            int b;
            b = hi ? 6 - j : j;
            if (m[b]) begin
                m_order[k][b] = 1'b1;
                k++;
            end
        end
`ifdef STRUM_ALTERNATE_EN
        if (k >= 2) m_flag = ~m_flag;
`endif
        m_s      = s;
        m_f      = s + (k - 1) * G;
        m_active = m;
    endfunction

    // Edge e: decisions are based on what the outputs showed in cycle e-1.
    function automatic void m_step(input int e);
        logic       evt;
        logic [6:0] nm;
        evt = (pluck != m_prev) && (pluck != 7'd0);
        if (e - 1 < m_f) begin
            if (evt) begin
                m_pend = pluck;
                m_pv   = 1'b1;
            end
        end else if (e - 1 == m_f) begin
            if (evt || m_pv) begin
                nm   = evt ? pluck : m_pend;
                m_pv = 1'b0;
                m_start(nm, m_f + G);
            end
        end else if (evt) begin
            m_chain = e;
            m_start(pluck, e);
        end
        m_prev = pluck;
    endfunction

    initial begin : model
        m_reset();
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (Reset_n !== 1'b1) m_reset();
            else begin
                cyc = cyc + 1;
                m_step(cyc);
            end
        end
    end

    initial begin : cmp
        logic [6:0] et;
        forever begin
            @(negedge Clk);
            if (Reset_n === 1'b1) begin
                et = '0;
                if (cyc >= m_s && cyc <= m_f && ((cyc - m_s) % G) == 0)
                    et = m_order[(cyc - m_s) / G];
                chk("trig", string_trig, et);
                chk("done", strum_done, cyc == m_f);
                chk("busy", busy, (cyc >= m_chain) && (cyc <= m_f));
                chk("active", active_mask, m_active);
                chk("pending", pending_valid, m_pv);
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [6:0] tl [0:127];
    logic       dl [0:127];
    logic       bl [0:127];
    logic       pl [0:127];

    // Drive p0 at tick 0, optionally p1 at tick t1 and p2 at tick t2, and log
    // outputs at ticks 1..n (one tick = one negedge).
    task automatic play(input logic [6:0] p0, input int t1, input logic [6:0] p1,
                        input int t2, input logic [6:0] p2, input int n);
        @(negedge Clk);
        pluck = p0;
        for (int t = 1; t <= n; t++) begin
            @(negedge Clk);
            tl[t] = string_trig;
            dl[t] = strum_done;
            bl[t] = busy;
            pl[t] = pending_valid;
            if (t == t1) pluck = p1;
            if (t == t2) pluck = p2;
        end
    endtask

    task automatic idle(input int n);
        pluck = '0;
        repeat (n) @(negedge Clk);
    endtask

    function automatic int npulse(input int a, input int b);
        int c;
        c = 0;
        for (int t = a; t <= b; t++) if (tl[t] != 7'd0) c++;
        return c;
    endfunction

    initial begin : drive
        logic [6:0] ev;
        int         bcnt;
        int         r;
        int         hold;
        logic [6:0] p;

        Reset_n = 1'b0;
        pluck   = '0;
        repeat (3) @(negedge Clk);
        chk("rst_trig", string_trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", strum_done, 0);
        chk("rst_active", active_mask, 0);
        chk("rst_pending", pending_valid, 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // single note
        play(7'b0000010, -1, 0, -1, 0, 8);
        chk("single_trig", tl[1], 7'b0000010);
        chk("single_done", dl[1], 1);
        chk("single_busy_off", bl[2], 0);
        chk("single_active", active_mask, 7'b0000010);
        chk("single_count", 7'(npulse(1, 8)), 1);
        idle(5);

        // chord: bits 2..6 at ticks 1,5,9,13,17
        play(7'b1111100, -1, 0, -1, 0, 24);
        for (int j = 0; j < 5; j++) begin
            ev = 7'b0000100;
            ev = ev << j;
            chk("chord_pulse", tl[1 + 4 * j], ev);
        end
        chk("chord_done", dl[17], 1);
        bcnt = 0;
        for (int t = 1; t <= 17; t++) if (bl[t]) bcnt++;
        chk("chord_busy_cnt", 7'(bcnt), 17);
        chk("chord_busy_off", bl[18], 0);
        chk("chord_count", 7'(npulse(1, 24)), 5);
        idle(5);

        // hold 100 cycles, release 3, re-press
        play(7'b0001000, 100, 7'b0000000, 103, 7'b0001000, 110);
        chk("hold_count", 7'(npulse(1, 110)), 2);
        chk("repress_pulse", tl[104], 7'b0001000);
        idle(5);

        // reset in the middle of a strum
        play(7'b1111000, -1, 0, -1, 0, 5);
        chk("pre_rst_second", 7'(npulse(1, 5)), 2);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midrst_trig", string_trig, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_active", active_mask, 0);
        chk("midrst_pending", pending_valid, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_first", string_trig, 7'b0001000);
        chk("post_rst_busy", busy, 1);
        idle(20);

        // queue and overwrite
        play(7'b1111111, 3, 7'b0000100, 6, 7'b0100000, 40);
        chk("queue_pv_before", pl[3], 0);
        chk("queue_pv", pl[4], 1);
        chk("queue_done", dl[25], 1);
        chk("queue_next", tl[29], 7'b0100000);
        chk("queue_after_cnt", 7'(npulse(26, 40)), 1);
        chk("queue_total", 7'(npulse(1, 40)), 8);
        idle(10);

`ifdef STRUM_ALTERNATE_EN
        // alternation restarts from chord 0 after reset
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        play(7'b1111100, -1, 0, -1, 0, 20);
        chk("alt0_first", tl[1], 7'b0000100);
        chk("alt0_last", tl[17], 7'b1000000);
        idle(3);
        play(7'b0000010, -1, 0, -1, 0, 4);
        idle(3);
        play(7'b1111100, -1, 0, -1, 0, 20);
        chk("alt1_first", tl[1], 7'b1000000);
        chk("alt1_last", tl[17], 7'b0000100);
        idle(5);
`endif

        // randomized patterns, holds, and occasional resets
        repeat (400) begin
            r = $urandom_range(0, 99);
            p = '0;
            if (r < 25) p = '0;
            else if (r < 55) p[$urandom_range(0, 6)] = 1'b1;
            else p = 7'($urandom);
            pluck = p;
            hold  = $urandom_range(1, 30);
            for (int h = 0; h < hold; h++) begin
                @(negedge Clk);
                if ($urandom_range(0, 299) == 0) begin
                    #2;
                    Reset_n = 1'b0;
                    @(negedge Clk);
                    Reset_n = 1'b1;
                end
            end
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
